sb_tx_arbiter: RTL

// Shares one sideband transmitter (SB_TX) among NUM_REQ message sources (link-training FSM, register access, ...).

---
 rtl/sb_tx_arbiter.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/sb_tx_arbiter.sv
// Round-robin arbiter sharing one sideband transmitter among NUM_REQ message sources.
// Spaces messages by an inter-message gap and bounds the wait for ack with a timeout.
module sb_tx_arbiter #(
  parameter  int NUM_REQ        = 4,
  parameter  int GAP_CYCLES     = 4,
  parameter  int TIMEOUT_CYCLES = 1024,
  localparam int ID_W           = $clog2(NUM_REQ)
) (
  input  logic                  clk_100MHz,
  input  logic                  reset,
  input  logic                  enable_i,
  input  logic [NUM_REQ-1:0]    req_valid_i,
  input  logic [NUM_REQ*64-1:0] req_data_i,
  output logic [NUM_REQ-1:0]    req_ready_o,
  output logic [63:0]           sb_data_o,
  output logic                  sb_valid_o,
  output logic                  sb_enable_o,
  input  logic                  sb_ack_i,
  output logic [ID_W-1:0]       grant_id_o,
  output logic                  busy_o,
  output logic                  timeout_o
);

  localparam int TO_W  = $clog2(TIMEOUT_CYCLES);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam logic [TO_W-1:0]  TO_MAX  = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(GAP_CYCLES - 1);
  localparam logic [ID_W-1:0]  ID_LAST = ID_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND    = 2'd1,
    ACK_LOW = 2'd2,
    GAP     = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [1:0]          ack_sync_q;
  logic                ack_s;
  logic                enable_q;
  logic                enable_fall_s;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic [ID_W-1:0]     grant_q, grant_d;
  logic [ID_W-1:0]     ptr_inc_s;
  logic [63:0]         data_q, data_d;
  logic                valid_q, valid_d;
  logic [NUM_REQ-1:0]  ready_q, ready_d;
  logic                busy_q;
  logic                timeout_q, timeout_d;
  logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
  logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
  logic [63:0]         req_data_s [NUM_REQ];
  logic                pick_found_s;
  logic [ID_W-1:0]     pick_idx_s;

  // First valid requester at or after the round-robin pointer, modulo NUM_REQ.
  function automatic logic [ID_W:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                            input logic [ID_W-1:0]    ptr);
    logic            found;
    logic [ID_W-1:0] idx;
    logic [ID_W-1:0] sel;
    found = 1'b0;
    sel   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = ID_W'((int'(ptr) + i) % NUM_REQ);
      if (!found && valid[idx]) begin
        found = 1'b1;
        sel   = idx;
      end else begin
        found = found;
      end
    end
    return {found, sel};
  endfunction

  // sb_ack_i comes from the 800MHz SB_TX domain; only the synchronized copy is used.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      ack_sync_q <= 2'b00;
    end else begin
      ack_sync_q <= {ack_sync_q[0], sb_ack_i};
    end
  end

  assign ack_s         = ack_sync_q[1];
  assign enable_fall_s = enable_q & ~enable_i;
  assign ptr_inc_s     = (grant_q == ID_LAST) ? {ID_W{1'b0}} : grant_q + ID_W'(1);

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_data_s[i] = req_data_i[64*i +: 64];
    end
  end

  always_comb begin
    {pick_found_s, pick_idx_s} = rr_pick(req_valid_i, ptr_q);
  end

  // Next-state and output logic; disabling aborts any transfer without a ready pulse.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    data_d    = data_q;
    valid_d   = valid_q;
    ready_d   = {NUM_REQ{1'b0}};
    to_cnt_d  = to_cnt_q;
    gap_cnt_d = gap_cnt_q;
    if (enable_fall_s) begin
      timeout_d = 1'b0;
    end else begin
      timeout_d = timeout_q;
    end

    if (!enable_i && (state_q != IDLE)) begin
      state_d = IDLE;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          // A stale ack from an aborted transfer must drain before the next grant.
          if (enable_i && pick_found_s && !ack_s) begin
            grant_d  = pick_idx_s;
            data_d   = req_data_s[pick_idx_s];
            valid_d  = 1'b1;
            to_cnt_d = {TO_W{1'b0}};
            state_d  = SEND;
          end else begin
            state_d = IDLE;
          end
        end
        SEND: begin
          if (ack_s) begin
            valid_d          = 1'b0;
            ready_d[grant_q] = 1'b1;
            ptr_d            = ptr_inc_s;
            state_d          = ACK_LOW;
          end else if (to_cnt_q == TO_MAX) begin
            valid_d   = 1'b0;
            timeout_d = 1'b1;
            ptr_d     = ptr_inc_s;
            state_d   = ACK_LOW;
          end else begin
            to_cnt_d = to_cnt_q + TO_W'(1);
          end
        end
        ACK_LOW: begin
          if (!ack_s) begin
            gap_cnt_d = {GAP_W{1'b0}};
            state_d   = GAP;
          end else begin
            state_d = ACK_LOW;
          end
        end
        GAP: begin
          if (gap_cnt_q == GAP_MAX) begin
            state_d = IDLE;
          end else begin
            gap_cnt_d = gap_cnt_q + GAP_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      enable_q  <= 1'b0;
      ptr_q     <= {ID_W{1'b0}};
      grant_q   <= {ID_W{1'b0}};
      data_q    <= 64'h0;
      valid_q   <= 1'b0;
      ready_q   <= {NUM_REQ{1'b0}};
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      to_cnt_q  <= {TO_W{1'b0}};
      gap_cnt_q <= {GAP_W{1'b0}};
    end else begin
      state_q   <= state_d;
      enable_q  <= enable_i;
      ptr_q     <= ptr_d;
      grant_q   <= grant_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ready_q   <= ready_d;
      busy_q    <= (state_d != IDLE);
      timeout_q <= timeout_d;
      to_cnt_q  <= to_cnt_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

  assign req_ready_o = ready_q;
  assign sb_data_o   = data_q;
  assign sb_valid_o  = valid_q;
  assign sb_enable_o = enable_q;
  assign grant_id_o  = grant_q;
  assign busy_o      = busy_q;
  assign timeout_o   = timeout_q;

endmodule
